mbtrain_center_sweep_ctrl: RTL and testbench



---
 rtl/mbtrain_center_sweep_ctrl_if.sv | 34 +++
 rtl/mbtrain_center_sweep_ctrl.sv | 228 ++++++++++++++++++++++
 tb/tb_mbtrain_center_sweep_ctrl.sv | 453 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mbtrain_center_sweep_ctrl_if.sv
// Sideband and point-test bundle for the MBTRAIN eye-centering controller.
// slave: controller side (sends sb messages, drives o_pt_en); master: partner/test side.
interface mbtrain_center_sweep_ctrl_if #(
    parameter int NUM_LANES = 16,
    parameter int MSG_W     = 4
) ();
    logic [MSG_W-1:0]     i_sb_msg;
    logic                 i_sb_valid;
    logic [MSG_W-1:0]     o_sb_msg;
    logic                 o_sb_valid;
    logic                 o_pt_en;
    logic                 i_test_ack;
    logic [NUM_LANES-1:0] i_lanes_result;

    modport slave (
        input  i_sb_msg,
        input  i_sb_valid,
        input  i_test_ack,
        input  i_lanes_result,
        output o_sb_msg,
        output o_sb_valid,
        output o_pt_en
    );

    modport master (
        output i_sb_msg,
        output i_sb_valid,
        output i_test_ack,
        output i_lanes_result,
        input  o_sb_msg,
        input  o_sb_valid,
        input  o_pt_en
    );
endinterface

// File: rtl/mbtrain_center_sweep_ctrl.sv
// MBTRAIN eye-centering controller: sweeps PI codes 0..PI_MAX, finds the
// longest contiguous passing window and programs the PI to its center.
// Ports: clk, rst (sync, active high), i_en (step enable, drop = abort),
//   i_lane_mask (lanes that must pass), bus (sideband + point test bundle),
//   o_pi_code (PI control word), o_done / o_fail (step complete / failed).
module mbtrain_center_sweep_ctrl #(
    parameter int NUM_LANES      = 16,
    parameter int PI_W           = 4,
    parameter int PI_MAX         = 15,
    parameter int MSG_W          = 4,
    parameter int MSG_START_REQ  = 1,
    parameter int MSG_START_RESP = 2,
    parameter int MSG_END_REQ    = 3,
    parameter int MSG_END_RESP   = 4,
    parameter int SETTLE_CYC     = 4,
    parameter int TIMEOUT_CYC    = 1024
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_en,
    input  logic [NUM_LANES-1:0] i_lane_mask,
    mbtrain_center_sweep_ctrl_if.slave bus,
    output logic [PI_W-1:0]      o_pi_code,
    output logic                 o_done,
    output logic                 o_fail
);

    localparam int LEN_W = PI_W + 1;
    localparam int TO_W  = $clog2(TIMEOUT_CYC + 1);
    localparam int ST_W  = $clog2(SETTLE_CYC + 1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_START_REQ,
        S_WAIT_START,
        S_SET_PI,
        S_SETTLE,
        S_TEST,
        S_EVAL,
        S_END_REQ,
        S_WAIT_END,
        S_DONE
    } state_t;

    state_t               r_state;
    logic [NUM_LANES-1:0] r_mask;
    logic [PI_W-1:0]      r_pi;
    logic [PI_W-1:0]      r_cur_start;
    logic [PI_W-1:0]      r_best_start;
    logic [LEN_W-1:0]     r_cur_len;
    logic [LEN_W-1:0]     r_best_len;
    logic                 r_pass;
    logic [TO_W-1:0]      r_tcnt;
    logic [ST_W-1:0]      r_scnt;
    logic [PI_W-1:0]      r_pi_code;
    logic [MSG_W-1:0]     r_sb_msg;
    logic                 r_sb_valid;
    logic                 r_pt_en;
    logic                 r_done;
    logic                 r_fail;

    logic                 w_lane_pass;
    logic                 w_start_ok;
    logic                 w_end_ok;
    logic                 w_to;
    logic                 w_settled;
    logic                 w_last;
    logic [LEN_W-1:0]     w_run_len;
    logic [PI_W-1:0]      w_run_start;
    logic                 w_upd;
    logic [LEN_W-1:0]     w_best_len_n;
    logic [PI_W-1:0]      w_best_start_n;
    logic [PI_W-1:0]      w_center;

    // Unmasked lanes are forced to pass, so an all-zero mask passes everywhere.
    assign w_lane_pass = ((bus.i_lanes_result & r_mask) == r_mask);

    assign w_start_ok = bus.i_sb_valid
                     && (bus.i_sb_msg == MSG_W'(MSG_START_RESP));
    assign w_end_ok   = bus.i_sb_valid
                     && (bus.i_sb_msg == MSG_W'(MSG_END_RESP));
    assign w_to       = (r_tcnt == TO_W'(TIMEOUT_CYC - 1));
    assign w_settled  = (r_scnt == ST_W'(SETTLE_CYC - 1));
    assign w_last     = (r_pi == PI_W'(PI_MAX));

    // Run/best trackers as they will look after this EVAL cycle.
    assign w_run_len   = r_pass ? (r_cur_len + LEN_W'(1)) : '0;
    assign w_run_start = (r_pass && (r_cur_len == '0)) ? r_pi : r_cur_start;
    // Strict compare: an equal-length later window never displaces the first.
    assign w_upd          = r_pass && (w_run_len > r_best_len);
    assign w_best_len_n   = w_upd ? w_run_len : r_best_len;
    assign w_best_start_n = w_upd ? w_run_start : r_best_start;

    // Floor center; the sum never exceeds PI_MAX so truncation is lossless.
    assign w_center = PI_W'(LEN_W'(w_best_start_n)
                    + ((w_best_len_n - LEN_W'(1)) >> 1));

    always_ff @(posedge clk) begin
        if (rst || !i_en) begin
            r_state      <= S_IDLE;
            r_mask       <= '0;
            r_pi         <= '0;
            r_cur_start  <= '0;
            r_best_start <= '0;
            r_cur_len    <= '0;
            r_best_len   <= '0;
            r_pass       <= 1'b0;
            r_tcnt       <= '0;
            r_scnt       <= '0;
            r_pi_code    <= '0;
            r_sb_msg     <= '0;
            r_sb_valid   <= 1'b0;
            r_pt_en      <= 1'b0;
            r_done       <= 1'b0;
            r_fail       <= 1'b0;
        end else begin
            r_sb_valid <= 1'b0;
            r_sb_msg   <= '0;
            unique case (r_state)
                S_IDLE: begin
                    r_mask       <= i_lane_mask;
                    r_pi         <= '0;
                    r_cur_start  <= '0;
                    r_best_start <= '0;
                    r_cur_len    <= '0;
                    r_best_len   <= '0;
                    r_pi_code    <= '0;
                    r_sb_valid   <= 1'b1;
                    r_sb_msg     <= MSG_W'(MSG_START_REQ);
                    r_state      <= S_START_REQ;
                end
                S_START_REQ: begin
                    r_tcnt  <= '0;
                    r_state <= S_WAIT_START;
                end
                S_WAIT_START: begin
                    if (w_start_ok) begin
                        r_pi_code <= r_pi;
                        r_state   <= S_SET_PI;
                    end else if (w_to) begin
                        r_pi_code <= '0;
                        r_done    <= 1'b1;
                        r_fail    <= 1'b1;
                        r_state   <= S_DONE;
                    end else begin
                        r_tcnt <= r_tcnt + TO_W'(1);
                    end
                end
                S_SET_PI: begin
                    r_scnt  <= '0;
                    r_state <= S_SETTLE;
                end
                S_SETTLE: begin
                    if (w_settled) begin
                        r_tcnt  <= '0;
                        r_pt_en <= 1'b1;
                        r_state <= S_TEST;
                    end else begin
                        r_scnt <= r_scnt + ST_W'(1);
                    end
                end
                S_TEST: begin
                    if (bus.i_test_ack) begin
                        r_pass  <= w_lane_pass;
                        r_pt_en <= 1'b0;
                        r_state <= S_EVAL;
                    end else if (w_to) begin
                        r_pt_en   <= 1'b0;
                        r_pi_code <= '0;
                        r_done    <= 1'b1;
                        r_fail    <= 1'b1;
                        r_state   <= S_DONE;
                    end else begin
                        r_tcnt <= r_tcnt + TO_W'(1);
                    end
                end
                S_EVAL: begin
                    r_cur_len    <= w_run_len;
                    r_cur_start  <= w_run_start;
                    r_best_len   <= w_best_len_n;
                    r_best_start <= w_best_start_n;
                    if (w_last) begin
                        r_pi_code  <= (w_best_len_n == '0) ? '0 : w_center;
                        r_sb_valid <= 1'b1;
                        r_sb_msg   <= MSG_W'(MSG_END_REQ);
                        r_state    <= S_END_REQ;
                    end else begin
                        r_pi      <= r_pi + PI_W'(1);
                        r_pi_code <= r_pi + PI_W'(1);
                        r_state   <= S_SET_PI;
                    end
                end
                S_END_REQ: begin
                    r_tcnt  <= '0;
                    r_state <= S_WAIT_END;
                end
                S_WAIT_END: begin
                    if (w_end_ok) begin
                        r_done  <= 1'b1;
                        r_fail  <= (r_best_len == '0);
                        r_state <= S_DONE;
                    end else if (w_to) begin
                        r_pi_code <= '0;
                        r_done    <= 1'b1;
                        r_fail    <= 1'b1;
                        r_state   <= S_DONE;
                    end else begin
                        r_tcnt <= r_tcnt + TO_W'(1);
                    end
                end
                S_DONE: begin
                    r_state <= S_DONE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.o_sb_msg   = r_sb_msg;
    assign bus.o_sb_valid = r_sb_valid;
    assign bus.o_pt_en    = r_pt_en;
    assign o_pi_code      = r_pi_code;
    assign o_done         = r_done;
    assign o_fail         = r_fail;

endmodule

// File: tb/tb_mbtrain_center_sweep_ctrl.sv
// Self-checking bench for mbtrain_center_sweep_ctrl: random point-test results
// against a window-enumerating reference model, plus directed corner scenarios.
module tb_mbtrain_center_sweep_ctrl;

    localparam int NL   = 4;
    localparam int PW   = 4;
    localparam int MW   = 4;
    localparam int TO   = 1024;
    localparam logic [MW-1:0] M_SREQ  = 4'd1;
    localparam logic [MW-1:0] M_SRESP = 4'd2;
    localparam logic [MW-1:0] M_EREQ  = 4'd3;
    localparam logic [MW-1:0] M_ERESP = 4'd4;

    typedef logic [NL-1:0] res_t [16];

    logic          clk = 1'b0;
    logic          rst;
    logic          i_en;
    logic [NL-1:0] i_lane_mask;
    logic [PW-1:0] o_pi_code;
    logic          o_done;
    logic          o_fail;

    int checks   = 0;
    int failures = 0;
    int n_sreq   = 0;
    int n_ereq   = 0;
    int n_pt     = 0;

    mbtrain_center_sweep_ctrl_if #(.NUM_LANES(NL), .MSG_W(MW)) bus ();

    mbtrain_center_sweep_ctrl #(
        .NUM_LANES(NL), .PI_W(PW), .PI_MAX(15), .MSG_W(MW),
        .MSG_START_REQ(1), .MSG_START_RESP(2),
        .MSG_END_REQ(3), .MSG_END_RESP(4),
        .SETTLE_CYC(4), .TIMEOUT_CYC(TO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .i_en       (i_en),
        .i_lane_mask(i_lane_mask),
        .bus        (bus.slave),
        .o_pi_code  (o_pi_code),
        .o_done     (o_done),
        .o_fail     (o_fail)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.o_sb_valid && bus.o_sb_msg == M_SREQ) n_sreq <= n_sreq + 1;
        if (bus.o_sb_valid && bus.o_sb_msg == M_EREQ) n_ereq <= n_ereq + 1;
        if (bus.o_pt_en) n_pt <= n_pt + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [MW-1:0] m);
        bus.i_sb_msg   = m;
        bus.i_sb_valid = 1'b1;
        tick();
        bus.i_sb_valid = 1'b0;
        bus.i_sb_msg   = '0;
    endtask

    // Expected center: longest all-pass window, earliest start on ties; -1 = none.
    function automatic int model_center(input logic [NL-1:0] mask,
                                        input res_t res);
        bit p [16];
        bit all;
        for (int c = 0; c < 16; c++) p[c] = ((res[c] & mask) == mask);
        for (int len = 16; len >= 1; len--) begin
            for (int s = 0; s + len <= 16; s++) begin
                all = 1'b1;
                for (int k = s; k < s + len; k++) if (!p[k]) all = 1'b0;
                if (all) return s + (len - 1) / 2;
            end
        end
        return -1;
    endfunction

    // Codes inside [a0,b0] or [a1,b1] pass all lanes; others fail one random lane.
    function automatic void mk_res(input int a0, input int b0,
                                   input int a1, input int b1,
                                   output res_t r);
        logic [NL-1:0] f;
        for (int c = 0; c < 16; c++) begin
            f = 4'd1 << $urandom_range(0, 3);
            if ((c >= a0 && c <= b0) || (c >= a1 && c <= b1)) r[c] = '1;
            else r[c] = ~f;
        end
    endfunction

    task automatic do_sweep(input logic [NL-1:0] mask, input res_t res,
                            input bit stray, input bit noise,
                            input int abort_at, input bit abort_rst,
                            output int codes_bad, output int done_lat,
                            output bit ok);
        int n;
        ok = 1'b1;
        codes_bad = 0;
        done_lat = -1;
        i_lane_mask = mask;
        i_en = 1'b1;
        n = 0;
        while (!(bus.o_sb_valid && bus.o_sb_msg == M_SREQ)) begin
            if (n == 20) begin ok = 1'b0; return; end
            tick();
            n++;
        end
        tick();
        if (stray) send(M_ERESP);
        repeat ($urandom_range(0, 3)) tick();
        send(M_SRESP);
        for (int c = 0; c < 16; c++) begin
            n = 0;
            while (!bus.o_pt_en) begin
                if (n == 60) begin ok = 1'b0; return; end
                bus.i_test_ack     = noise && ($urandom_range(0, 1) == 1);
                bus.i_lanes_result = '0;
                tick();
                n++;
            end
            bus.i_test_ack = 1'b0;
            if (o_pi_code != PW'(c)) codes_bad++;
            if (c == abort_at) begin
                if (abort_rst) rst = 1'b1;
                else i_en = 1'b0;
                tick();
                return;
            end
            repeat ($urandom_range(0, 3)) tick();
            bus.i_lanes_result = res[c];
            bus.i_test_ack     = 1'b1;
            tick();
            bus.i_test_ack     = 1'b0;
            bus.i_lanes_result = '0;
        end
        n = 0;
        while (!(bus.o_sb_valid && bus.o_sb_msg == M_EREQ)) begin
            if (n == 20) begin ok = 1'b0; return; end
            tick();
            n++;
        end
        tick();
        repeat ($urandom_range(0, 3)) tick();
        send(M_ERESP);
        n = 0;
        while (!o_done) begin
            if (n == 20) begin ok = 1'b0; return; end
            tick();
            n++;
        end
        done_lat = n;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        i_en = 1'b1;
        repeat (3) tick();
        checks++;
        if ({bus.o_sb_valid, bus.o_sb_msg, bus.o_pt_en, o_pi_code,
             o_done, o_fail} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: got %b required all zero",
                     {bus.o_sb_valid, bus.o_sb_msg, bus.o_pt_en, o_pi_code,
                      o_done, o_fail});
        end
        i_en = 1'b0;
        rst = 1'b0;
        tick();
        checks++;
        if (o_done !== 1'b0 || bus.o_sb_valid !== 1'b0) begin
            failures++;
            $display("FAIL idle_outputs: done=%b sbv=%b required 0 0",
                     o_done, bus.o_sb_valid);
        end
    endtask

    task automatic test_basic_window();
        res_t r;
        int cb, dl, s0, e0;
        bit ok;
        mk_res(4, 10, -1, -2, r);
        s0 = n_sreq;
        e0 = n_ereq;
        do_sweep(4'hF, r, 1'b0, 1'b0, -1, 1'b0, cb, dl, ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL basic_handshake: stalled"); end
        checks++;
        if (o_pi_code !== 4'd7) begin
            failures++;
            $display("FAIL basic_pi: got %0d required 7", o_pi_code);
        end
        checks++;
        if (o_fail !== 1'b0) begin
            failures++;
            $display("FAIL basic_fail: got %b required 0", o_fail);
        end
        checks++;
        if (cb != 0) begin
            failures++;
            $display("FAIL basic_code_order: %0d codes out of order required 0", cb);
        end
        checks++;
        if (dl != 0) begin
            failures++;
            $display("FAIL basic_done_latency: got %0d required 0", dl);
        end
        checks++;
        if (n_sreq - s0 != 1 || n_ereq - e0 != 1) begin
            failures++;
            $display("FAIL basic_msg_count: start=%0d end=%0d required 1 1",
                     n_sreq - s0, n_ereq - e0);
        end
        repeat (5) tick();
        checks++;
        if (o_done !== 1'b1 || o_pi_code !== 4'd7) begin
            failures++;
            $display("FAIL done_held: done=%b pi=%0d required 1 7",
                     o_done, o_pi_code);
        end
        i_en = 1'b0;
        tick();
        checks++;
        if (o_done !== 1'b0 || o_pi_code !== '0) begin
            failures++;
            $display("FAIL done_release: done=%b pi=%0d required 0 0",
                     o_done, o_pi_code);
        end
    endtask

    task automatic test_windows();
        res_t r;
        int cb, dl;
        bit ok;
        int a0 [2] = '{2, 1};
        int b0 [2] = '{3, 3};
        int a1 [2] = '{8, 9};
        int b1 [2] = '{12, 11};
        int ex [2] = '{10, 2};
        for (int t = 0; t < 2; t++) begin
            mk_res(a0[t], b0[t], a1[t], b1[t], r);
            do_sweep(4'hF, r, 1'b0, 1'b1, -1, 1'b0, cb, dl, ok);
            checks++;
            if (!ok || o_pi_code !== PW'(ex[t]) || o_fail !== 1'b0) begin
                failures++;
                $display("FAIL windows_%0d: ok=%b pi=%0d fail=%b required 1 %0d 0",
                         t, ok, o_pi_code, o_fail, ex[t]);
            end
            i_en = 1'b0;
            tick();
        end
    endtask

    task automatic test_lane_mask();
        res_t r;
        int cb, dl;
        bit ok;
        for (int c = 0; c < 16; c++) r[c] = 4'b1011;
        do_sweep(4'hF, r, 1'b0, 1'b0, -1, 1'b0, cb, dl, ok);
        checks++;
        if (!ok || o_fail !== 1'b1 || o_pi_code !== '0 || o_done !== 1'b1) begin
            failures++;
            $display("FAIL lane2_fail: ok=%b done=%b fail=%b pi=%0d required 1 1 1 0",
                     ok, o_done, o_fail, o_pi_code);
        end
        i_en = 1'b0;
        tick();
        do_sweep(4'hB, r, 1'b0, 1'b0, -1, 1'b0, cb, dl, ok);
        checks++;
        if (!ok || o_fail !== 1'b0 || o_pi_code !== 4'd7) begin
            failures++;
            $display("FAIL lane2_masked: ok=%b fail=%b pi=%0d required 1 0 7",
                     ok, o_fail, o_pi_code);
        end
        i_en = 1'b0;
        tick();
        for (int c = 0; c < 16; c++) r[c] = NL'($urandom);
        do_sweep(4'h0, r, 1'b0, 1'b0, -1, 1'b0, cb, dl, ok);
        checks++;
        if (!ok || o_fail !== 1'b0 || o_pi_code !== 4'd7) begin
            failures++;
            $display("FAIL mask_zero: ok=%b fail=%b pi=%0d required 1 0 7",
                     ok, o_fail, o_pi_code);
        end
        i_en = 1'b0;
        tick();
    endtask

    task automatic test_timeout();
        int n, p0, e0;
        p0 = n_pt;
        e0 = n_ereq;
        i_lane_mask = 4'hF;
        i_en = 1'b1;
        n = 0;
        while (!(bus.o_sb_valid && bus.o_sb_msg == M_SREQ) && n < 20) begin
            tick();
            n++;
        end
        // Response coincident with START_REQ must not be taken.
        send(M_SRESP);
        n = 0;
        while (!o_done && n < TO + 100) begin
            tick();
            n++;
        end
        checks++;
        if (n != TO) begin
            failures++;
            $display("FAIL timeout_cycles: got %0d required %0d", n, TO);
        end
        checks++;
        if (o_done !== 1'b1 || o_fail !== 1'b1 || o_pi_code !== '0) begin
            failures++;
            $display("FAIL timeout_flags: done=%b fail=%b pi=%0d required 1 1 0",
                     o_done, o_fail, o_pi_code);
        end
        checks++;
        if (n_pt != p0 || n_ereq != e0) begin
            failures++;
            $display("FAIL timeout_quiet: pt_cycles=%0d end_req=%0d required 0 0",
                     n_pt - p0, n_ereq - e0);
        end
        i_en = 1'b0;
        tick();
    endtask

    task automatic test_abort();
        res_t r1, r2;
        int cb, dl;
        bit ok;
        for (int k = 0; k < 2; k++) begin
            mk_res(0, 5, -1, -2, r1);
            do_sweep(4'hF, r1, 1'b0, 1'b0, 6, k[0], cb, dl, ok);
            checks++;
            if (!ok || {bus.o_sb_valid, bus.o_sb_msg, bus.o_pt_en, o_pi_code,
                        o_done, o_fail} !== '0) begin
                failures++;
                $display("FAIL abort_%0d_outputs: ok=%b pt_en=%b pi=%0d required 1 0 0",
                         k, ok, bus.o_pt_en, o_pi_code);
            end
            rst = 1'b0;
            mk_res(12, 13, -1, -2, r2);
            do_sweep(4'hF, r2, 1'b0, 1'b0, -1, 1'b0, cb, dl, ok);
            checks++;
            if (!ok || cb != 0 || o_pi_code !== 4'd12 || o_fail !== 1'b0) begin
                failures++;
                $display("FAIL abort_%0d_resweep: ok=%b bad=%0d pi=%0d required 1 0 12",
                         k, ok, cb, o_pi_code);
            end
            i_en = 1'b0;
            tick();
        end
    endtask

    task automatic test_stray_msg();
        res_t r;
        int cb, dl;
        bit ok;
        mk_res(5, 9, -1, -2, r);
        do_sweep(4'hF, r, 1'b1, 1'b0, -1, 1'b0, cb, dl, ok);
        checks++;
        if (!ok || cb != 0 || o_pi_code !== 4'd7 || o_fail !== 1'b0) begin
            failures++;
            $display("FAIL stray_msg: ok=%b bad=%0d pi=%0d fail=%b required 1 0 7 0",
                     ok, cb, o_pi_code, o_fail);
        end
        i_en = 1'b0;
        tick();
    endtask

    task automatic test_random();
        res_t r;
        int cb, dl, exp_c;
        bit ok;
        logic [NL-1:0] m;
        for (int it = 0; it < 10; it++) begin
            m = NL'($urandom);
            for (int c = 0; c < 16; c++)
                r[c] = ($urandom_range(0, 3) != 0) ? 4'hF : NL'($urandom);
            exp_c = model_center(m, r);
            do_sweep(m, r, 1'b0, 1'b1, -1, 1'b0, cb, dl, ok);
            checks++;
            if (!ok || (exp_c < 0 && (o_fail !== 1'b1 || o_pi_code !== '0))
                    || (exp_c >= 0 && (o_fail !== 1'b0
                                       || o_pi_code !== PW'(exp_c)))) begin
                failures++;
                $display("FAIL random_%0d: ok=%b pi=%0d fail=%b required center %0d",
                         it, ok, o_pi_code, o_fail, exp_c);
            end
            i_en = 1'b0;
            tick();
        end
    endtask

    task automatic test_back_to_back();
        res_t r;
        int cb, dl;
        bit ok;
        mk_res(0, 2, 13, 15, r);
        do_sweep(4'hF, r, 1'b0, 1'b0, -1, 1'b0, cb, dl, ok);
        checks++;
        if (!ok || o_pi_code !== 4'd1) begin
            failures++;
            $display("FAIL b2b_first: ok=%b pi=%0d required 1 1", ok, o_pi_code);
        end
        i_en = 1'b0;
        tick();
        mk_res(-1, -2, 15, 15, r);
        do_sweep(4'hF, r, 1'b0, 1'b0, -1, 1'b0, cb, dl, ok);
        checks++;
        if (!ok || cb != 0 || o_pi_code !== 4'd15 || o_fail !== 1'b0) begin
            failures++;
            $display("FAIL b2b_second: ok=%b pi=%0d fail=%b required 1 15 0",
                     ok, o_pi_code, o_fail);
        end
        i_en = 1'b0;
        tick();
    endtask

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        i_en = 1'b0;
        i_lane_mask = '0;
        bus.i_sb_msg = '0;
        bus.i_sb_valid = 1'b0;
        bus.i_test_ack = 1'b0;
        bus.i_lanes_result = '0;
        test_reset();
        test_basic_window();
        test_windows();
        test_lane_mask();
        test_timeout();
        test_abort();
        test_stray_msg();
        test_random();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
